// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state type, default sizing and the 3-sample majority vote.
// Contents:
//   rx_state_t        receiver FSM states
//   SAMPLE_RATIO_DEF  default sample ticks per bit
//   DATA_BITS_DEF     default data bits per frame
//   majority3         2-of-3 vote used at each bit centre
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int SAMPLE_RATIO_DEF = 16;
    localparam int DATA_BITS_DEF    = 8;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_oversample_rx_if.sv
// uart_oversample_rx_if: received-byte bundle from the UART receiver to its consumers.
// Signals:
//   rx_data     last correctly framed byte
//   rx_valid    one-clk pulse when rx_data updates
//   rx_idle     high while no frame is in progress
//   frame_err   one-clk pulse when the stop bit is sampled low
//   parity_err  one-clk pulse on parity mismatch
// Modports: master = receiver (drives), slave = consumer (reads).
interface uart_oversample_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEF
) ();

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_idle;
    logic                 frame_err;
    logic                 parity_err;

    modport master (output rx_data, rx_valid, rx_idle, frame_err, parity_err);
    modport slave  (input  rx_data, rx_valid, rx_idle, frame_err, parity_err);

endinterface

// File: rtl/uart_bit_sampler.sv
// uart_bit_sampler: per-bit tick counter and centre 3-sample majority window.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   sample_tick   oversampling enable; the counter only moves on it
//   active        low while the receiver is idle; holds the counter at 0
//   din_s         synchronised serial line
//   bit_done      tick at the last sample of a bit period
//   centre_valid  tick at the third centre sample; centre_bit is valid then
//   centre_bit    majority of the three centre samples
module uart_bit_sampler
    import uart_pkg::*;
#(
    parameter int SAMPLE_RATIO = SAMPLE_RATIO_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_tick,
    input  logic active,
    input  logic din_s,
    output logic bit_done,
    output logic centre_valid,
    output logic centre_bit
);

    localparam int TW = $clog2(SAMPLE_RATIO);
    localparam int C  = SAMPLE_RATIO / 2;
    localparam logic [TW-1:0] LAST  = TW'(SAMPLE_RATIO - 1);
    localparam logic [TW-1:0] C_LO  = TW'(C - 1);
    localparam logic [TW-1:0] C_MID = TW'(C);
    localparam logic [TW-1:0] C_HI  = TW'(C + 1);

    logic [TW-1:0] tick_cnt;
    logic          s_lo;
    logic          s_mid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            s_lo     <= 1'b1;
            s_mid    <= 1'b1;
        end else if (!active) begin
            tick_cnt <= '0;
        end else if (sample_tick) begin
            tick_cnt <= (tick_cnt == LAST) ? '0 : tick_cnt + 1'b1;
            if (tick_cnt == C_LO) s_lo <= din_s;
            if (tick_cnt == C_MID) s_mid <= din_s;
        end
    end

    // The third sample is the live line, so the vote is ready on the C+1 tick itself.
    assign bit_done     = active & sample_tick & (tick_cnt == LAST);
    assign centre_valid = active & sample_tick & (tick_cnt == C_HI);
    assign centre_bit   = majority3(s_lo, s_mid, din_s);

endmodule

// File: rtl/uart_oversample_rx.sv
// uart_oversample_rx: oversampling 8N1 UART receiver with centre majority vote.
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   din          raw asynchronous serial line, idles high
//   sample_tick  one-clk enable at BAUD*SAMPLE_RATIO
//   rx           uart_oversample_rx_if.master: rx_data, rx_valid, rx_idle, frame_err, parity_err
// Optional feature: define RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_oversample_rx
    import uart_pkg::*;
#(
    parameter int SAMPLE_RATIO = SAMPLE_RATIO_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF,
    parameter int SYNC_STAGES  = 2
`ifdef RX_PARITY_EN
    ,
    parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   din,
    input  logic                   sample_tick,
    uart_oversample_rx_if.master   rx
);

    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = PARITY;
`else
    localparam rx_state_t AFTER_DATA = STOP;
`endif

    logic [SYNC_STAGES-1:0] sync;
    logic                   din_s;
    rx_state_t              state, state_n;
    logic [BW-1:0]          bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_n;
    logic [DATA_BITS-1:0]   data_n;
    logic                   valid_n, ferr_n;
    // Cleared after a framing error so a held-low line cannot retrigger until it goes high.
    logic                   armed, armed_n;
    logic                   bit_done, centre_valid, centre_bit;
`ifdef RX_PARITY_EN
    logic                   par_bad, par_bad_n, perr_n;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) sync <= '1;
        else sync <= {sync[SYNC_STAGES-2:0], din};
    end

    assign din_s = sync[SYNC_STAGES-1];

    uart_bit_sampler #(
        .SAMPLE_RATIO (SAMPLE_RATIO)
    ) u_sampler (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .active       (state != IDLE),
        .din_s        (din_s),
        .bit_done     (bit_done),
        .centre_valid (centre_valid),
        .centre_bit   (centre_bit)
    );

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        data_n    = rx.rx_data;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        armed_n   = armed;
`ifdef RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sample_tick && din_s) armed_n = 1'b1;
                if (sample_tick && !din_s && armed) state_n = START;
            end
            START: begin
                if (centre_valid && centre_bit) state_n = IDLE;
                else if (bit_done) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                // LSB arrives first, so shifting in at the MSB leaves the byte in order.
                if (centre_valid) shift_n = {centre_bit, shift_reg[DATA_BITS-1:1]};
                if (bit_done) begin
                    bit_cnt_n = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) state_n = AFTER_DATA;
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (centre_valid) par_bad_n = (^shift_reg) ^ centre_bit ^ PARITY_ODD;
                if (bit_done) state_n = STOP;
            end
`endif
            STOP: begin
                // Deciding at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (centre_valid) begin
                    state_n = IDLE;
                    data_n  = centre_bit ? shift_reg : rx.rx_data;
                    valid_n = centre_bit;
                    ferr_n  = !centre_bit;
                    armed_n = centre_bit;
`ifdef RX_PARITY_EN
                    perr_n  = par_bad;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            armed        <= 1'b1;
            rx.rx_data   <= '0;
            rx.rx_valid  <= 1'b0;
            rx.frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shift_reg    <= shift_n;
            armed        <= armed_n;
            rx.rx_data   <= data_n;
            rx.rx_valid  <= valid_n;
            rx.frame_err <= ferr_n;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_bad       <= 1'b0;
            rx.parity_err <= 1'b0;
        end else begin
            par_bad       <= par_bad_n;
            rx.parity_err <= perr_n;
        end
    end
`else
    assign rx.parity_err = 1'b0;
`endif

    assign rx.rx_idle = (state == IDLE);

endmodule

// File: tb/tb_uart_oversample_rx.sv
// tb_uart_oversample_rx: directed self-checking bench for uart_oversample_rx.
// Ports: none (top-level bench); drives din/sample_tick, watches the rx interface.
module tb_uart_oversample_rx;

    localparam int SR = 16;
`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // Start edge seen on tick 1 (tick_cnt=0 after it); stop centre read as tick_cnt=9 of the last bit.
    localparam int LATENCY = 2 + SR * (FRAME_BITS - 1) + SR / 2 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b1;
    logic sample_tick = 1'b0;

    int errors = 0;
    int checks = 0;
    int tick_no = 0;
    int n_valid = 0, n_ferr = 0, n_perr = 0;
    int n_overlap = 0, n_long = 0, n_valid_busy = 0;
    int valid_tick = 0;
    logic prev_valid = 1'b0, prev_ferr = 1'b0;
    logic [7:0] got[$];

    uart_oversample_rx_if #(.DATA_BITS(8)) rx_if ();

    uart_oversample_rx #(
        .SAMPLE_RATIO (SR),
        .DATA_BITS    (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .sample_tick (sample_tick),
        .rx          (rx_if.master)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (3) @(posedge clk);
        #1 sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
    end

    always @(posedge clk) if (sample_tick) tick_no <= tick_no + 1;

    always @(negedge clk) begin
        if (rx_if.rx_valid === 1'b1) begin
            n_valid++;
            valid_tick = tick_no;
            got.push_back(rx_if.rx_data);
            if (rx_if.rx_idle !== 1'b1) n_valid_busy++;
        end
        if (rx_if.frame_err === 1'b1) n_ferr++;
        if (rx_if.parity_err === 1'b1) n_perr++;
        if (rx_if.rx_valid === 1'b1 && rx_if.frame_err === 1'b1) n_overlap++;
        if ((rx_if.rx_valid === 1'b1 && prev_valid) || (rx_if.frame_err === 1'b1 && prev_ferr)) n_long++;
        prev_valid = (rx_if.rx_valid === 1'b1);
        prev_ferr  = (rx_if.frame_err === 1'b1);
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!sample_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        din = b;
        wait_ticks(SR);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop);
        din = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        din = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rx_if.rx_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", rx_if.rx_idle); end
        checks++; if (rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_if.rx_valid); end
        checks++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", rx_if.frame_err); end
        din = 1'b1;
        rst_n = 1'b1;
        wait_ticks(4);
        checks++; if (rx_if.rx_idle !== 1'b1) begin errors++; $display("FAIL reset_release_idle got=%b exp=1", rx_if.rx_idle); end
        checks++; if (n_valid !== 0) begin errors++; $display("FAIL reset_release_valid got=%0d exp=0", n_valid); end
    endtask

    task automatic test_single_frame();
        int t0, v0, f0;
        t0 = tick_no; v0 = n_valid; f0 = n_ferr;
        send_frame(8'h55, 1'b1);
        checks++; if (n_valid !== v0 + 1) begin errors++; $display("FAIL single_count got=%0d exp=%0d", n_valid - v0, 1); end
        checks++; if (rx_if.rx_data !== 8'h55) begin errors++; $display("FAIL single_data got=%h exp=55", rx_if.rx_data); end
        checks++; if (valid_tick - t0 !== LATENCY) begin errors++; $display("FAIL single_latency got=%0d exp=%0d", valid_tick - t0, LATENCY); end
        checks++; if (rx_if.rx_idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%b exp=1", rx_if.rx_idle); end
        checks++; if (n_ferr !== f0) begin errors++; $display("FAIL single_ferr got=%0d exp=0", n_ferr - f0); end
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = n_ferr;
        got.delete();
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        checks++; if (got.size() !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", got.size()); end
        checks++; if (got[0] !== 8'hA3) begin errors++; $display("FAIL b2b_first got=%h exp=a3", got[0]); end
        checks++; if (got[1] !== 8'h0F) begin errors++; $display("FAIL b2b_second got=%h exp=0f", got[1]); end
        checks++; if (n_ferr !== f0) begin errors++; $display("FAIL b2b_ferr got=%0d exp=0", n_ferr - f0); end
    endtask

    task automatic test_start_glitch();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        din = 1'b0;
        wait_ticks(5);
        din = 1'b1;
        wait_ticks(5);
        checks++; if (rx_if.rx_idle !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", rx_if.rx_idle); end
        wait_ticks(1);
        checks++; if (rx_if.rx_idle !== 1'b1) begin errors++; $display("FAIL glitch_idle got=%b exp=1", rx_if.rx_idle); end
        wait_ticks(SR);
        checks++; if (n_valid !== v0 || n_ferr !== f0) begin errors++; $display("FAIL glitch_pulses got=%0d/%0d exp=0/0", n_valid - v0, n_ferr - f0); end
    endtask

    task automatic test_framing_error();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        checks++; if (n_ferr !== f0 + 1) begin errors++; $display("FAIL ferr_count got=%0d exp=1", n_ferr - f0); end
        checks++; if (n_valid !== v0) begin errors++; $display("FAIL ferr_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (rx_if.rx_data !== 8'h0F) begin errors++; $display("FAIL ferr_data_hold got=%h exp=0f", rx_if.rx_data); end
        wait_ticks(4);
        send_frame(8'h81, 1'b1);
        checks++; if (rx_if.rx_data !== 8'h81) begin errors++; $display("FAIL ferr_recover_data got=%h exp=81", rx_if.rx_data); end
        checks++; if (n_valid !== v0 + 1 || n_ferr !== f0 + 1) begin errors++; $display("FAIL ferr_recover_pulses got=%0d/%0d exp=1/1", n_valid - v0, n_ferr - f0); end
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0;
        v0 = n_valid; f0 = n_ferr;
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rst_n = 1'b0;
        din = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        checks++; if (rx_if.rx_idle !== 1'b1 || rx_if.rx_data !== 8'h00) begin errors++; $display("FAIL abort_state got=%b/%h exp=1/00", rx_if.rx_idle, rx_if.rx_data); end
        wait_ticks(4);
        send_frame(8'h7E, 1'b1);
        checks++; if (rx_if.rx_data !== 8'h7E) begin errors++; $display("FAIL abort_next_data got=%h exp=7e", rx_if.rx_data); end
        checks++; if (n_valid !== v0 + 1 || n_ferr !== f0) begin errors++; $display("FAIL abort_pulses got=%0d/%0d exp=1/0", n_valid - v0, n_ferr - f0); end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        int v0, p0;
        logic [7:0] d;
        v0 = n_valid; p0 = n_perr; d = 8'h7E;
        wait_ticks(4);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(~(^d));
        send_bit(1'b1);
        checks++; if (n_perr !== p0 + 1) begin errors++; $display("FAIL parity_err_count got=%0d exp=1", n_perr - p0); end
        checks++; if (n_valid !== v0 + 1 || rx_if.rx_data !== 8'h7E) begin errors++; $display("FAIL parity_valid got=%0d/%h exp=1/7e", n_valid - v0, rx_if.rx_data); end
    endtask
`endif

    task automatic test_pulse_rules();
        checks++; if (n_overlap !== 0) begin errors++; $display("FAIL pulse_overlap got=%0d exp=0", n_overlap); end
        checks++; if (n_long !== 0) begin errors++; $display("FAIL pulse_width got=%0d exp=0", n_long); end
        checks++; if (n_valid_busy !== 0) begin errors++; $display("FAIL valid_idle got=%0d exp=0", n_valid_busy); end
`ifndef RX_PARITY_EN
        checks++; if (n_perr !== 0) begin errors++; $display("FAIL parity_tied got=%0d exp=0", n_perr); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_start_glitch();
        test_framing_error();
        test_reset_mid_frame();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
